// File: rtl/sprite_pkg.sv
// sprite_pkg: shared colour type, fixed 8-entry palette and screen constants.
package sprite_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
  localparam rgb444_t [0:7] PALETTE = {
    12'h000, 12'hf00, 12'h0f0, 12'h00f, 12'hff0, 12'h0ff, 12'hf0f, 12'hfff
  };
  function automatic rgb444_t pal_lookup(input logic [2:0] i);
    return PALETTE[i];
  endfunction
endpackage

// File: rtl/sprite_frame_rom.sv
// sprite_frame_rom: synchronous-read texel ROM; contents are a fixed address-derived pattern.
module sprite_frame_rom #(
  parameter int DEPTH = 2304,
  parameter int IDX_W = 3,
  parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  output logic [IDX_W-1:0] data
);
  always_ff @(posedge clk) data <= IDX_W'(addr ^ (addr >> 4));
endmodule

// File: rtl/sprite_anim_engine.sv
// sprite_anim_engine: tear-free scaled animated sprite renderer, 3-cycle pixel pipeline.
// Define SPRITE_MIRROR_EN to honour the mirror port; otherwise it is ignored.
module sprite_anim_engine
  import sprite_pkg::*;
#(
  parameter int SPR_W = 24,
  parameter int SPR_H = 24,
  parameter int FRAMES = 4,
  parameter int SCALE_SH = 1,
  parameter int IDX_W = 3,
  parameter int HOLD = 8,
  parameter int FW = FRAMES > 1 ? $clog2(FRAMES) : 1
) (
  input  logic          vga_clk,
  input  logic          Reset,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic          frame_start,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic          mirror,
  input  logic          anim_en,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          hit,
  output logic [FW-1:0] frame_idx
);
  localparam int PIX = SPR_W * SPR_H;
  localparam int DEPTH = FRAMES * PIX;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = HOLD > 1 ? $clog2(HOLD) : 1;
  logic [9:0] sx, sy;
  logic [CW-1:0] cnt;
  logic [10:0] dx, dy, tx, ty, tx_eff;
  logic in_box, vld1, vld2, opaque;
  logic [AW-1:0] addr, addr_c;
  logic [IDX_W-1:0] idx;
  rgb444_t col;
  // 11-bit differences cannot wrap once the >= guards hold, so edges clip cleanly
  assign dx = {1'b0, DrawX} - {1'b0, sx};
  assign dy = {1'b0, DrawY} - {1'b0, sy};
  assign in_box = DrawX >= sx && DrawY >= sy &&
                  dx < 11'(SPR_W << SCALE_SH) && dy < 11'(SPR_H << SCALE_SH);
  assign tx = dx >> SCALE_SH;
  assign ty = dy >> SCALE_SH;
`ifdef SPRITE_MIRROR_EN
  logic smir;
  always_ff @(posedge vga_clk) smir <= Reset ? 1'b0 : frame_start ? mirror : smir;
  assign tx_eff = smir ? 11'(SPR_W - 1) - tx : tx;
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign tx_eff = tx;
`endif
  assign addr_c = AW'(32'(frame_idx) * PIX + 32'(ty) * SPR_W + 32'(tx_eff));
  sprite_frame_rom #(.DEPTH(DEPTH), .IDX_W(IDX_W), .AW(AW)) u_rom (
    .clk(vga_clk), .addr(addr), .data(idx)
  );
  assign col = pal_lookup(3'(idx));
  assign opaque = vld2 && idx != '0;
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      sx <= '0;
      sy <= '0;
      cnt <= '0;
      frame_idx <= '0;
      vld1 <= 1'b0;
      vld2 <= 1'b0;
      addr <= '0;
      hit <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      if (frame_start) begin
        sx <= pos_x;
        sy <= pos_y;
        if (anim_en) begin
          cnt <= cnt == CW'(HOLD - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(HOLD - 1))
            frame_idx <= frame_idx == FW'(FRAMES - 1) ? '0 : frame_idx + 1'b1;
        end
      end
      vld1 <= in_box && blank;
      addr <= addr_c;
      vld2 <= vld1;
      hit <= opaque;
      {red, green, blue} <= opaque ? col : '0;
    end
  end
endmodule

// File: tb/tb_sprite_anim_engine.sv
// tb_sprite_anim_engine: directed checks of position, clipping, transparency, tearing, animation, reset, mirror.
module tb_sprite_anim_engine;
  logic vga_clk = 0, Reset = 1, blank = 1, frame_start = 0, mirror = 0, anim_en = 0;
  logic [9:0] DrawX = 0, DrawY = 0, pos_x = 0, pos_y = 0;
  logic [3:0] red, green, blue;
  logic hit;
  logic [1:0] frame_idx;
  int errors = 0, checks = 0;
  logic [1:0] anim_seq [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

  sprite_anim_engine #(
    .SPR_W(24), .SPR_H(24), .FRAMES(4), .SCALE_SH(1), .IDX_W(3), .HOLD(2)
  ) dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .mirror(mirror),
    .anim_en(anim_en), .red(red), .green(green), .blue(blue), .hit(hit),
    .frame_idx(frame_idx)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic h, input logic [11:0] c);
    chk(tag, {3'b0, hit, red, green, blue}, {3'b0, h, c});
  endtask

  task automatic chk_fi(input string tag, input logic [1:0] f);
    chk(tag, {14'b0, frame_idx}, {14'b0, f});
  endtask

  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b);
    DrawX = x;
    DrawY = y;
    blank = b;
    repeat (3) @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1;
    @(posedge vga_clk);
    #1;
    frame_start = 0;
  endtask

  initial begin
    repeat (4) @(posedge vga_clk);
    #1;
    chk_px("reset_px", 0, 12'h000);
    chk_fi("reset_fi", 2'd0);
    Reset = 0;
    px(10, 0, 1);
    chk_px("origin_sx0", 1, 12'h0ff);
    pos_x = 100;
    pos_y = 50;
    pulse();
    px(100, 50, 1);
    chk_px("tl_transparent", 0, 12'h000);
    px(110, 50, 1);
    chk_px("idx5", 1, 12'h0ff);
    px(112, 50, 1);
    chk_px("idx6", 1, 12'hf0f);
    px(100, 52, 1);
    chk_px("row1", 1, 12'hf00);
    px(147, 97, 1);
    chk_px("br_inbox", 1, 12'hff0);
    px(148, 50, 1);
    chk_px("right_clip", 0, 12'h000);
    px(147, 98, 1);
    chk_px("bottom_clip", 0, 12'h000);
    px(99, 50, 1);
    chk_px("left_out", 0, 12'h000);
    px(110, 50, 0);
    chk_px("blank", 0, 12'h000);
    chk_fi("anim_off", 2'd0);
    pos_x = 200;
    px(110, 50, 1);
    chk_px("tear_hold", 1, 12'h0ff);
    px(210, 50, 1);
    chk_px("tear_new_out", 0, 12'h000);
    pulse();
    px(110, 50, 1);
    chk_px("moved_old", 0, 12'h000);
    DrawX = 210;
    repeat (2) @(posedge vga_clk);
    #1;
    chk_px("lat2", 0, 12'h000);
    @(posedge vga_clk);
    #1;
    chk_px("lat3", 1, 12'h0ff);
    anim_en = 1;
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk_fi($sformatf("anim_seq%0d", i), anim_seq[i]);
      if (i == 1) begin
        px(200, 50, 1);
        chk_px("frame1_px", 1, 12'hff0);
      end
    end
    repeat (4) pulse();
    chk_fi("fi_to2", 2'd2);
    anim_en = 0;
    repeat (3) pulse();
    chk_fi("anim_hold", 2'd2);
    anim_en = 1;
    pulse();
    chk_fi("cnt_held", 2'd2);
    px(210, 50, 1);
    chk_px("frame2_px", 1, 12'h0ff);
    pos_x = 300;
    pos_y = 300;
    Reset = 1;
    frame_start = 1;
    @(posedge vga_clk);
    #1;
    chk_px("rst_out", 0, 12'h000);
    chk_fi("rst_fi", 2'd0);
    Reset = 0;
    frame_start = 0;
    DrawX = 10;
    DrawY = 0;
    repeat (2) @(posedge vga_clk);
    #1;
    chk_px("rst_lat2", 0, 12'h000);
    @(posedge vga_clk);
    #1;
    chk_px("rst_sx0", 1, 12'h0ff);
    pos_x = 0;
    pos_y = 0;
    pulse();
    chk_fi("rst_cnt", 2'd0);
    pulse();
    chk_fi("rst_cnt2", 2'd1);
    anim_en = 0;
    mirror = 1;
    pulse();
`ifdef SPRITE_MIRROR_EN
    px(0, 0, 1);
    chk_px("mirror_col0", 1, 12'h0f0);
    px(10, 0, 1);
    chk_px("mirror_col5", 1, 12'hfff);
`else
    px(0, 0, 1);
    chk_px("nomirror_col0", 1, 12'hff0);
    px(10, 0, 1);
    chk_px("nomirror_col5", 1, 12'hf00);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
